// File: rtl/hdmi_timing_gen.sv
// =============================================================================
//  Module      : hdmi_timing_gen
//  Description : Free-running video timing master for the HDMI pixel clock
//                domain. Generates the FIFO pop strobe (hdmi_blank low during
//                active pixels), the frame/sof markers, and realigns returned
//                FIFO pixels with hsync/vsync/de for the TMDS encoder.
//                Default timing: 1280x720p60 (74.25 MHz pixel clock).
//  Ports       : hdmi_clk      in   pixel clock
//                hdmi_reset_n  in   asynchronous active-low reset
//                hdmi_frame    out  high while in active lines
//                hdmi_blank    out  low during active pixels (FIFO pop)
//                sof           out  1-clk pulse on first active pixel of frame
//                pix_in        in   24-bit RGB pixel from the FIFO
//                vid_hsync     out  hsync aligned to vid_pix
//                vid_vsync     out  vsync aligned to vid_pix
//                vid_de        out  data enable aligned to vid_pix
//                vid_pix       out  24-bit RGB to encoder, 0 when vid_de=0
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module hdmi_timing_gen #(
   parameter int   H_ACTIVE = 1280,
   parameter int   H_FP     = 110,
   parameter int   H_SYNC   = 40,
   parameter int   H_BP     = 220,
   parameter int   V_ACTIVE = 720,
   parameter int   V_FP     = 5,
   parameter int   V_SYNC   = 5,
   parameter int   V_BP     = 20,
   parameter logic HS_POL   = 1'b1,
   parameter logic VS_POL   = 1'b1,
   parameter int   PIX_LAT  = 0
) (
   input  logic        hdmi_clk,
   input  logic        hdmi_reset_n,
   output logic        hdmi_frame,
   output logic        hdmi_blank,
   output logic        sof,
   input  logic [23:0] pix_in,
   output logic        vid_hsync,
   output logic        vid_vsync,
   output logic        vid_de,
   output logic [23:0] vid_pix
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Boundaries are held one bit wider than the counters so that an edge
   // equal to the full counter range (e.g. H_TOTAL = 4096) does not alias to 0.
   localparam logic [12:0] C_H_ACT   = 13'(H_ACTIVE);
   localparam logic [12:0] C_HS_BEG  = 13'(H_ACTIVE + H_FP);
   localparam logic [12:0] C_HS_END  = 13'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] C_H_LAST  = 12'(H_TOTAL - 1);
   localparam logic [11:0] C_V_ACT   = 12'(V_ACTIVE);
   localparam logic [11:0] C_VS_BEG  = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] C_VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] C_V_LAST  = 11'(V_TOTAL - 1);

   logic [11:0] r_h_cnt;
   logic [10:0] r_v_cnt;

   logic        r_blank;
   logic        r_frame;
   logic        r_sof;
   logic        r_hs;
   logic        r_vs;

   logic [12:0] w_h_ext;
   logic [11:0] w_v_ext;
   logic        w_h_act;
   logic        w_v_act;

   logic        w_de_d;
   logic        w_hs_d;
   logic        w_vs_d;

   assign w_h_ext = {1'b0, r_h_cnt};
   assign w_v_ext = {1'b0, r_v_cnt};
   assign w_h_act = (w_h_ext < C_H_ACT);
   assign w_v_act = (w_v_ext < C_V_ACT);

   // -------------------------------------------------------------------------
   // Raster counters: line order is active, front porch, sync, back porch.
   // -------------------------------------------------------------------------
   always_ff @(posedge hdmi_clk or negedge hdmi_reset_n) begin
      if (!hdmi_reset_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_h_cnt == C_H_LAST) begin
         r_h_cnt <= '0;
         if (r_v_cnt == C_V_LAST) begin
            r_v_cnt <= '0;
         end else begin
            r_v_cnt <= r_v_cnt + 11'd1;
         end
      end else begin
         r_h_cnt <= r_h_cnt + 12'd1;
      end
   end

   // -------------------------------------------------------------------------
   // Strobes, registered one clock after the counter state. vsync follows the
   // line counter, so its edges naturally land on h == 0.
   // -------------------------------------------------------------------------
   always_ff @(posedge hdmi_clk or negedge hdmi_reset_n) begin
      if (!hdmi_reset_n) begin
         r_blank <= 1'b1;
         r_frame <= 1'b0;
         r_sof   <= 1'b0;
         r_hs    <= 1'b0;
         r_vs    <= 1'b0;
      end else begin
         r_blank <= !(w_h_act && w_v_act);
         r_frame <= w_v_act;
         r_sof   <= (r_h_cnt == 12'd0) && (r_v_cnt == 11'd0);
         r_hs    <= (w_h_ext >= C_HS_BEG) && (w_h_ext < C_HS_END);
         r_vs    <= (w_v_ext >= C_VS_BEG) && (w_v_ext < C_VS_END);
      end
   end

   assign hdmi_blank = r_blank;
   assign hdmi_frame = r_frame;
   assign sof        = r_sof;

   // -------------------------------------------------------------------------
   // Control delay matching the FIFO read latency, so that de/hs/vs arrive at
   // the output register in the same clock as the pixel they describe.
   // -------------------------------------------------------------------------
   generate
      if (PIX_LAT == 0) begin : g_lat_zero
         assign w_de_d = ~r_blank;
         assign w_hs_d = r_hs;
         assign w_vs_d = r_vs;
      end else begin : g_lat_pipe
         logic [2:0] r_sr [PIX_LAT];

         always_ff @(posedge hdmi_clk or negedge hdmi_reset_n) begin
            if (!hdmi_reset_n) begin
               for (int i = 0; i < PIX_LAT; i++) begin
                  r_sr[i] <= 3'b000;
               end
            end else begin
               r_sr[0] <= {r_hs, r_vs, ~r_blank};
               for (int i = 1; i < PIX_LAT; i++) begin
                  r_sr[i] <= r_sr[i-1];
               end
            end
         end

         assign {w_hs_d, w_vs_d, w_de_d} = r_sr[PIX_LAT-1];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Output register: captures the pixel, zeroes it outside de, and applies
   // sync polarity.
   // -------------------------------------------------------------------------
   always_ff @(posedge hdmi_clk or negedge hdmi_reset_n) begin
      if (!hdmi_reset_n) begin
         vid_de    <= 1'b0;
         vid_pix   <= '0;
         vid_hsync <= ~HS_POL;
         vid_vsync <= ~VS_POL;
      end else begin
         vid_de    <= w_de_d;
         vid_pix   <= w_de_d ? pix_in : 24'd0;
         vid_hsync <= w_hs_d ? HS_POL : ~HS_POL;
         vid_vsync <= w_vs_d ? VS_POL : ~VS_POL;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hdmi_timing_gen.sv
// =============================================================================
//  Module      : tb_hdmi_timing_gen
//  Description : Self-checking bench for hdmi_timing_gen. Three instances:
//                A small raster with PIX_LAT=0, the same raster with PIX_LAT=2
//                and inverted sync polarity, and the default 720p timing.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_hdmi_timing_gen;

   typedef struct packed {
      logic        blank;
      logic        frame;
      logic        sof;
      logic        hs;
      logic        vs;
      logic        de;
      logic [23:0] pix;
   } obs_t;

   logic        clk;
   logic        rst_n;
   logic [23:0] pix_a;
   logic [23:0] pix_b;
   logic [23:0] pix_c;
   int          e;          // rising edges since reset release
   int          tests;
   int          fails;
   int          pops_a;

   logic a_frame, a_blank, a_sof, a_hs, a_vs, a_de;
   logic b_frame, b_blank, b_sof, b_hs, b_vs, b_de;
   logic c_frame, c_blank, c_sof, c_hs, c_vs, c_de;
   logic [23:0] a_pix, b_pix, c_pix;

   hdmi_timing_gen #(
      .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
      .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(3),
      .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(0)
   ) u_a (
      .hdmi_clk(clk), .hdmi_reset_n(rst_n), .hdmi_frame(a_frame),
      .hdmi_blank(a_blank), .sof(a_sof), .pix_in(pix_a), .vid_hsync(a_hs),
      .vid_vsync(a_vs), .vid_de(a_de), .vid_pix(a_pix)
   );

   hdmi_timing_gen #(
      .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
      .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(3),
      .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(2)
   ) u_b (
      .hdmi_clk(clk), .hdmi_reset_n(rst_n), .hdmi_frame(b_frame),
      .hdmi_blank(b_blank), .sof(b_sof), .pix_in(pix_b), .vid_hsync(b_hs),
      .vid_vsync(b_vs), .vid_de(b_de), .vid_pix(b_pix)
   );

   hdmi_timing_gen u_c (
      .hdmi_clk(clk), .hdmi_reset_n(rst_n), .hdmi_frame(c_frame),
      .hdmi_blank(c_blank), .sof(c_sof), .pix_in(pix_c), .vid_hsync(c_hs),
      .vid_vsync(c_vs), .vid_de(c_de), .vid_pix(c_pix)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) e <= 0;
      else        e <= e + 1;
   end

   // Expected outputs after e edges since release. Strobes describe raster
   // position e-1; vid_* describe position e-PIX_LAT-2. Pixels are driven so
   // that the value captured for raster position q equals q.
   function automatic obs_t model(input int ee, input int ha, input int hfp,
                                  input int hsw, input int hbp, input int va,
                                  input int vfp, input int vsw, input int vbp,
                                  input int lat, input logic hpol, input logic vpol);
      obs_t r;
      int ht, ft, p, q, h, v;
      ht = ha + hfp + hsw + hbp;
      ft = ht * (va + vfp + vsw + vbp);
      r.blank = 1'b1; r.frame = 1'b0; r.sof = 1'b0;
      r.hs = ~hpol;   r.vs = ~vpol;   r.de = 1'b0; r.pix = 24'd0;
      if (ee >= 1) begin
         p = (ee - 1) % ft;
         h = p % ht;
         v = p / ht;
         r.blank = !(h < ha && v < va);
         r.frame = (v < va);
         r.sof   = (p == 0);
      end
      q = ee - lat - 2;
      if (q >= 0) begin
         p = q % ft;
         h = p % ht;
         v = p / ht;
         r.de  = (h < ha && v < va);
         r.hs  = (h >= ha + hfp && h < ha + hfp + hsw) ? hpol : ~hpol;
         r.vs  = (v >= va + vfp && v < va + vfp + vsw) ? vpol : ~vpol;
         r.pix = r.de ? 24'(q) : 24'd0;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (e=%0d): got %0h, expected %0h", name, e, act, exp);
      end
   endtask

   task automatic check_all(input int ee);
      obs_t ea, eb, ec, oa, ob, oc;
      ea = model(ee, 16, 3, 4, 5, 6, 2, 2, 3, 0, 1'b1, 1'b1);
      eb = model(ee, 16, 3, 4, 5, 6, 2, 2, 3, 2, 1'b0, 1'b0);
      ec = model(ee, 1280, 110, 40, 220, 720, 5, 5, 20, 0, 1'b1, 1'b1);
      oa = '{a_blank, a_frame, a_sof, a_hs, a_vs, a_de, a_pix};
      ob = '{b_blank, b_frame, b_sof, b_hs, b_vs, b_de, b_pix};
      oc = '{c_blank, c_frame, c_sof, c_hs, c_vs, c_de, c_pix};
      chk("model_A", 32'(oa), 32'(ea));
      chk("model_B", 32'(ob), 32'(eb));
      chk("model_C", 32'(oc), 32'(ec));
   endtask

   // Per-cycle model comparison, including while reset is held.
   always @(negedge clk) begin
      check_all(e);
   end

   // Hand-computed anchors. A/B raster: H_TOTAL=28, frame=364 clks.
   always @(negedge clk) begin
      if (rst_n) begin
         if (e == 0) pops_a = 0;
         if (e >= 1 && e <= 364 && a_blank == 1'b0) pops_a++;
         case (e)
            0:    chk("A_blank_before_edge", 32'(a_blank), 32'd1);
            1:    begin
                     chk("A_first_blank", 32'(a_blank), 32'd0);
                     chk("A_first_frame", 32'(a_frame), 32'd1);
                     chk("A_first_sof",   32'(a_sof),   32'd1);
                  end
            2:    begin
                     chk("A_sof_width",   32'(a_sof),  32'd0);
                     chk("A_de_rise",     32'(a_de),   32'd1);
                     chk("A_pix_first",   32'(a_pix),  32'd0);
                  end
            3:    begin
                     chk("B_de_still_low", 32'(b_de), 32'd0);
                     chk("B_hs_idle_high", 32'(b_hs), 32'd1);
                  end
            4:    begin
                     chk("B_de_rise",   32'(b_de),  32'd1);
                     chk("B_pix_first", 32'(b_pix), 32'd0);
                  end
            17:   chk("A_pix_last",  32'(a_pix), 32'd15);
            18:   begin
                     chk("A_de_fall",  32'(a_de),  32'd0);
                     chk("A_pix_zero", 32'(a_pix), 32'd0);
                  end
            19:   chk("B_pix_last", 32'(b_pix), 32'd15);
            20:   chk("B_pix_zero", 32'(b_pix), 32'd0);
            22:   chk("B_hs_before", 32'(b_hs), 32'd1);
            23:   chk("B_hs_active", 32'(b_hs), 32'd0);
            27:   chk("B_hs_after",  32'(b_hs), 32'd1);
            32:   chk("B_line1_first", 32'(b_pix), 32'd28);
            47:   chk("B_line1_last",  32'(b_pix), 32'd43);
            168:  chk("A_frame_last_active", 32'(a_frame), 32'd1);
            169:  chk("A_frame_blank_line",  32'(a_frame), 32'd0);
            227:  chk("B_vs_before", 32'(b_vs), 32'd1);
            228:  chk("B_vs_active", 32'(b_vs), 32'd0);
            283:  chk("B_vs_last",   32'(b_vs), 32'd0);
            284:  chk("B_vs_after",  32'(b_vs), 32'd1);
            364:  chk("A_sof_not_early", 32'(a_sof), 32'd0);
            365:  begin
                     chk("A_sof_period", 32'(a_sof), 32'd1);
                     chk("A_pops_frame", 32'(pops_a), 32'd96);
                  end
            1281: chk("C_de_last",    32'(c_de), 32'd1);
            1282: chk("C_de_fall",    32'(c_de), 32'd0);
            1391: chk("C_hs_before",  32'(c_hs), 32'd0);
            1392: chk("C_hs_rise",    32'(c_hs), 32'd1);
            1431: chk("C_hs_last",    32'(c_hs), 32'd1);
            1432: chk("C_hs_fall",    32'(c_hs), 32'd0);
            1651: chk("C_line_end",   32'(c_de), 32'd0);
            1652: chk("C_line_period", 32'(c_de), 32'd1);
            default: ;
         endcase
      end
   end

   // Pixel sources: the value presented in cycle j is the raster position
   // whose pop happened PIX_LAT clocks earlier.
   initial begin
      pix_a = 24'd0;
      pix_b = 24'd0;
      pix_c = 24'd0;
      forever begin
         @(posedge clk);
         #1;
         pix_a = 24'(e - 1);
         pix_b = 24'(e - 3);
         pix_c = 24'(e - 1);
      end
   end

   initial begin
      tests  = 0;
      fails  = 0;
      pops_a = 0;
      rst_n  = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      // Brings instance A to raster position h=10, v=3 (active, mid-frame).
      repeat (3735) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_A_blank", 32'(a_blank), 32'd1);
      chk("async_A_frame", 32'(a_frame), 32'd0);
      chk("async_A_de",    32'(a_de),    32'd0);
      chk("async_A_pix",   32'(a_pix),   32'd0);
      chk("async_B_hs",    32'(b_hs),    32'd1);
      chk("async_B_vs",    32'(b_vs),    32'd1);
      check_all(0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (800) @(posedge clk);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
